abro_sequencer: RTL and testbench
=================================

# abro_sequencer

Programmable stimulus sequencer for the opposite end of the abro_state_machine interface. It stores a short sequence of {A, B} input steps from a host, plays them to the ABRO machine one step per clock, and monitors the returned O. At the end it reports how many sampled cycles had O high and the final O value. It sits between a host/register block and abro_state_machine, driving that machine's A/B inputs and consuming its O output.

## Interface
- DEPTH, 8: number of step entries in the pattern memory (power of two, 2..16)
- CNT_W, 8: width of the O-high counter
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- load_valid  input  1  host presents a step on load_data
- load_data  input  2  step value, bit1 = A, bit0 = B
- load_ready  output  1  step accepted on an edge where load_valid and load_ready are both high
- start  input  1  begin playback (IDLE or DONE only)
- clear  input  1  empty the pattern memory and return to IDLE (IDLE or DONE only)
- O_in  input  1  O from abro_state_machine
- A  output  1  registered A drive to abro_state_machine
- B  output  1  registered B drive to abro_state_machine
- busy  output  1  high in PLAY and DRAIN
- done  output  1  high in DONE
- o_count  output  CNT_W  number of sampled cycles with O_in = 1, saturating at all-ones
- last_o  output  1  O_in value sampled for the final step
- state  output  4  one-hot: 0001 IDLE, 0010 PLAY, 0100 DRAIN, 1000 DONE

## Operation
- Reset (asynchronous, reset_n low): state = IDLE (0001). A, B, busy, done, last_o = 0. o_count = 0. Length len = 0, pointers = 0. Memory contents don't care.
- IDLE:
  - load_ready = (len < DEPTH).
  - An accepted step writes mem[len] and increments len. Load is only possible in IDLE.
  - clear: len = 0 and o_count = 0. clear has priority over start and load on the same edge.
  - start with len > 0: go to PLAY.
  - start with len = 0: ignored; stay in IDLE.
- PLAY: steps mem[0] .. mem[len-1] drive {A, B}, one per cycle. After the last step, go to DRAIN with A = B = 0. start, clear and load_valid are ignored.
- DRAIN: one cycle. It collects O for the final step, then goes to DONE.
- DONE:
  - done = 1; A = B = 0; o_count and last_o hold.
  - start replays the same memory (o_count restarts at 0).
  - clear goes to IDLE with len = 0.
  - load_ready = 0.
- O sampling: an internal flag samp = the value of "A/B carried a step" in the previous cycle. On every edge with samp = 1:
  - o_count increments if O_in = 1 (saturating);
  - last_o <= O_in.
  - This means step i's response is sampled one cycle after step i is driven, which matches the registered ABRO machine.
- Arithmetic: len and pointers are clog2(DEPTH)+1 bits wide; len == DEPTH means full.
- Reset mid-playback: immediate return to IDLE, memory emptied (len = 0), A = B = 0.

## Timing
- Edge E0 samples start = 1: state becomes PLAY, {A, B} = mem[0], o_count = 0, busy = 1.
- Cycle k after E0 (k = 0 .. len-1): {A, B} = mem[k].
- Edge E_len: go to DRAIN, A = B = 0.
- Edge E_len+1: go to DONE, done = 1, busy = 0.
- O_in is sampled at edges E2 .. E_len+1, which is exactly len samples.
- Playback latency from start to done: len + 1 cycles.
- A full load followed by start plays DEPTH steps. A load attempt when full leaves load_ready = 0 and len unchanged.

## Test plan
- Reset: assert reset_n = 0 mid-cycle → outputs go to zero and state = 0001 before the next edge, with no clock needed.
- Load/full: with DEPTH = 8, offer 9 steps with load_valid held high → exactly 8 accepted. load_ready drops in the cycle after the 8th acceptance; len = 8.
- Playback sequence:
  - Load {10, 01, 11, 10}, pulse start.
  - A/B show 10, 01, 11, 10 on consecutive cycles, then 00.
  - Bench drives O_in = 0, 0, 0, 1, 1 on cycles 0..4 → o_count = 2, last_o = 1.
  - done rises 5 cycles after the start edge.
- Replay/clear: from DONE, pulse start → the identical A/B sequence replays and o_count restarts at 0. Then clear → state = 0001, len = 0. A following start is ignored (state stays 0001).
- Ignored inputs: pulse start, clear and load_valid during PLAY → sequence, len and o_count are unaffected. Also assert clear and start on the same edge in DONE → result is IDLE.
- Reset mid-operation: deassert reset_n during cycle 2 of playback → A = B = 0 and state = 0001 immediately. After release, load_ready = 1 and len = 0.
- Saturation: with CNT_W = 2, play 8 steps with O_in held at 1 → o_count = 3.

Source files
------------

// File: rtl/abro_sequencer.sv
// Stimulus sequencer for abro_state_machine: stores {A,B} steps from a host,
// plays them one per clock and tallies the returned O.
module abro_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [1:0]       load_data,
  output logic             load_ready,
  input  logic             start,
  input  logic             clear,
  input  logic             O_in,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] o_count,
  output logic             last_o,
  output logic [3:0]       state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_PLAY  = 4'b0010,
    S_DRAIN = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    len_reg, len_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic [1:0]       ab_reg, ab_next;
  logic             carry_reg, carry_next;
  logic             samp_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             last_reg, last_next;
  logic             load_fire;

  logic [1:0] mem [DEPTH];

  assign load_ready = (state_reg == S_IDLE) && (len_reg < PW'(DEPTH));
  // clear and a successful start both win over a load on the same edge
  assign load_fire  = load_valid && load_ready && !clear &&
                      !(start && (len_reg != '0));

  always_ff @(posedge clk) begin
    if (load_fire) mem[len_reg[AW-1:0]] <= load_data;
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    ptr_next   = ptr_reg;
    ab_next    = ab_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;

    // samp_reg marks the cycle in which the previous step's O is valid
    if (samp_reg) begin
      if (O_in && (cnt_reg != '1)) cnt_next = cnt_reg + CNT_W'(1);
      last_next = O_in;
    end

    case (state_reg)
      S_IDLE: begin
        if (clear) begin
          len_next = '0;
          cnt_next = '0;
        end else if (start && (len_reg != '0)) begin
          state_next = S_PLAY;
          ab_next    = mem[0];
          ptr_next   = PW'(1);
          carry_next = 1'b1;
          cnt_next   = '0;
        end else if (load_fire) begin
          len_next = len_reg + PW'(1);
        end
      end
      S_PLAY: begin
        if (ptr_reg == len_reg) begin
          state_next = S_DRAIN;
          ab_next    = 2'b00;
          carry_next = 1'b0;
        end else begin
          ab_next  = mem[ptr_reg[AW-1:0]];
          ptr_next = ptr_reg + PW'(1);
        end
      end
      S_DRAIN: state_next = S_DONE;
      S_DONE: begin
        if (clear) begin
          state_next = S_IDLE;
          len_next   = '0;
          cnt_next   = '0;
        end else if (start) begin
          state_next = S_PLAY;
          ab_next    = mem[0];
          ptr_next   = PW'(1);
          carry_next = 1'b1;
          cnt_next   = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      len_reg   <= '0;
      ptr_reg   <= '0;
      ab_reg    <= 2'b00;
      carry_reg <= 1'b0;
      samp_reg  <= 1'b0;
      cnt_reg   <= '0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      ptr_reg   <= ptr_next;
      ab_reg    <= ab_next;
      carry_reg <= carry_next;
      samp_reg  <= carry_reg;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  assign A       = ab_reg[1];
  assign B       = ab_reg[0];
  assign busy    = (state_reg == S_PLAY) || (state_reg == S_DRAIN);
  assign done    = (state_reg == S_DONE);
  assign o_count = cnt_reg;
  assign last_o  = last_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_abro_sequencer.sv
// Directed bench for abro_sequencer: a main instance (CNT_W=8) and a
// saturation instance (CNT_W=2) share every input.
module tb_abro_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_valid, start, clear, O_in;
  logic [1:0] load_data;
  logic       load_ready, A, B, busy, done, last_o;
  logic [7:0] o_count;
  logic [3:0] state;
  logic       s_load_ready, s_A, s_B, s_busy, s_done, s_last_o;
  logic [1:0] s_o_count;
  logic [3:0] s_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  abro_sequencer #(.DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .clear(clear), .O_in(O_in),
    .A(A), .B(B), .busy(busy), .done(done), .o_count(o_count),
    .last_o(last_o), .state(state)
  );

  abro_sequencer #(.DEPTH(8), .CNT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(s_load_ready), .start(start), .clear(clear), .O_in(O_in),
    .A(s_A), .B(s_B), .busy(s_busy), .done(s_done), .o_count(s_o_count),
    .last_o(s_last_o), .state(s_state)
  );

  typedef struct {
    logic       o;
    logic       noise;
    logic [1:0] ab;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } row_t;

  row_t rows[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic load_pattern();
    load(2'b10); load(2'b01); load(2'b11); load(2'b10);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // cycle k of the table is the cycle after start edge E0 plus k
  task automatic run_table(input string tag, input logic use_noise);
    for (int k = 0; k < 6; k++) begin
      O_in = rows[k].o;
      if (use_noise && rows[k].noise) begin
        start = 1'b1; clear = 1'b1; load_valid = 1'b1; load_data = 2'b11;
      end
      chk($sformatf("%s_c%0d_ab", tag, k), {30'd0, A, B}, {30'd0, rows[k].ab});
      chk($sformatf("%s_c%0d_busy", tag, k), {31'd0, busy}, {31'd0, rows[k].busy});
      chk($sformatf("%s_c%0d_done", tag, k), {31'd0, done}, {31'd0, rows[k].done});
      chk($sformatf("%s_c%0d_cnt", tag, k), {24'd0, o_count}, {24'd0, rows[k].cnt});
      step();
      start = 1'b0; clear = 1'b0; load_valid = 1'b0; O_in = 1'b0;
    end
  endtask

  initial begin
    int acc;
    int c;
    logic [1:0] e;

    //             o     noise ab     busy  done  cnt
    rows[0] = '{1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 8'd0};
    rows[1] = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'd0};
    rows[2] = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 8'd0};
    rows[3] = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 8'd0};
    rows[4] = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'd1};
    rows[5] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'd2};

    reset_n = 1'b0; load_valid = 1'b0; load_data = 2'b00;
    start = 1'b0; clear = 1'b0; O_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    chk("rst_state", {28'd0, state}, 32'h1);
    chk("rst_ab", {30'd0, A, B}, 32'h0);
    chk("rst_cnt", {24'd0, o_count}, 32'h0);
    chk("rst_flags", {29'd0, busy, done, last_o}, 32'h0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'h1);

    // full: 9 offers with load_valid held high
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      load_valid = 1'b1;
      load_data  = 2'(i);
      if (load_ready) acc++;
      step();
    end
    load_valid = 1'b0;
    chk("full_accepted", acc, 8);
    chk("full_load_ready", {31'd0, load_ready}, 32'h0);

    pulse_start();
    c = 0;
    while (!done && c < 40) begin
      if (c < 8) begin
        e = 2'(c);
        chk($sformatf("full_c%0d_ab", c), {30'd0, A, B}, {30'd0, e});
      end
      step();
      c++;
    end
    chk("full_done_latency", c, 9);
    clear = 1'b1; step(); clear = 1'b0;
    chk("full_clear_state", {28'd0, state}, 32'h1);

    // playback
    load_pattern();
    pulse_start();
    run_table("play", 1'b0);
    chk("play_last_o", {31'd0, last_o}, 32'h1);
    chk("play_state", {28'd0, state}, 32'h8);

    // replay from DONE
    pulse_start();
    run_table("replay", 1'b0);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_state", {28'd0, state}, 32'h1);
    chk("clear_load_ready", {31'd0, load_ready}, 32'h1);
    pulse_start();
    chk("empty_start_state", {28'd0, state}, 32'h1);

    // start/clear/load during PLAY are ignored
    load_pattern();
    pulse_start();
    run_table("noise", 1'b1);
    clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
    chk("clr_start_state", {28'd0, state}, 32'h1);
    pulse_start();
    chk("clr_start_empty", {28'd0, state}, 32'h1);

    // asynchronous reset during cycle 2 of playback
    load_pattern();
    pulse_start();
    step();
    step();
    chk("mid_pre_ab", {30'd0, A, B}, 32'h3);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ab", {30'd0, A, B}, 32'h0);
    chk("mid_rst_state", {28'd0, state}, 32'h1);
    chk("mid_rst_busy", {31'd0, busy}, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("mid_rel_load_ready", {31'd0, load_ready}, 32'h1);
    pulse_start();
    chk("mid_rel_empty", {28'd0, state}, 32'h1);

    // saturation: 8 steps with O_in held high
    for (int i = 0; i < 8; i++) load(2'b11);
    pulse_start();
    O_in = 1'b1;
    c = 0;
    while (!done && c < 40) begin
      step();
      c++;
    end
    O_in = 1'b0;
    chk("sat_done_latency", c, 9);
    chk("sat_cnt_w2", {30'd0, s_o_count}, 32'h3);
    chk("sat_cnt_w8", {24'd0, o_count}, 32'h8);
    chk("sat_last_o", {31'd0, s_last_o}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
